// File: rtl/uart_programmer.sv
// uart_programmer: receives a program image over UART and writes it
// word by word through a request/grant memory write port.
// The packet is a 4-byte little-endian word count LEN, then LEN*4 data bytes.
// Optional feature macro: UART_PROGRAMMER_CHECKSUM_EN adds a trailing XOR
// checksum byte. The image is accepted only if that byte matches.
module uart_programmer #(
    parameter int unsigned            CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned            BAUD_RATE   = 115200,
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  programmer_enable_i,
    input  logic                  programmer_rx,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int unsigned     CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned     CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    // The line idles high, so all three reset to 1.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= programmer_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver next state. The start bit is rechecked at mid-bit, then there
    // is one sample per bit period. Strobes fire on the stop-bit sample.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + 1'b1;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver state register. Dropping the session enable discards any
    // partial byte.
    always_ff @(posedge clk_i) begin
        if (!reset_ni || !programmer_enable_i) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Session FSM, word assembly and write port
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
`ifdef UART_PROGRAMMER_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_e;

`ifdef UART_PROGRAMMER_CHECKSUM_EN
    localparam state_e S_AFTER_DATA = S_CSUM;
`else
    localparam state_e S_AFTER_DATA = S_DONE;
`endif

    state_e                state_q, state_d;
    logic [31:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           asm_q, asm_d;
    logic [31:0]           asm_cnt_q, asm_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           full_len;
    logic                  xfer;
    logic                  in_session;
`ifdef UART_PROGRAMMER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            csum_byte_q, csum_byte_d;
    logic                  csum_seen_q, csum_seen_d;
`endif

    assign xfer = req_q && mem_gnt_i;
`ifdef UART_PROGRAMMER_CHECKSUM_EN
    assign in_session = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    assign in_session = (state_q == S_LEN) || (state_q == S_DATA);
`endif
    assign full_len = {rx_shift_q, len_q[23:0]};

    // Session next state: length capture, word assembly into the holding
    // register, grant counting, overrun/framing/checksum checks.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        asm_cnt_d  = asm_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef UART_PROGRAMMER_CHECKSUM_EN
        csum_d      = csum_q;
        csum_byte_d = csum_byte_q;
        csum_seen_d = csum_seen_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_LEN;
            S_LEN: begin
                if (byte_valid_q) begin
                    len_d[{byte_cnt_q, 3'b000} +: 8] = rx_shift_q;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_PROGRAMMER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_shift_q;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (full_len == 32'd0) ? S_AFTER_DATA : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    req_d    = 1'b0;
                    wr_cnt_d = wr_cnt_q + 32'd1;
                    if (wr_cnt_q == len_q - 32'd1) begin
                        state_d = S_AFTER_DATA;
                    end
                end
                if (byte_valid_q) begin
                    if (asm_cnt_q != len_q) begin
                        asm_d[{byte_cnt_q, 3'b000} +: 8] = rx_shift_q;
                        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_PROGRAMMER_CHECKSUM_EN
                        csum_d = csum_q ^ rx_shift_q;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            if (req_q && !mem_gnt_i) begin
                                // Previous word still waiting: overrun.
                                state_d = S_ERROR;
                                req_d   = 1'b0;
                            end else begin
                                req_d     = 1'b1;
                                wdata_d   = {rx_shift_q, asm_q[23:0]};
                                addr_d    = BASE_ADDR + ADDR_WIDTH'({asm_cnt_q, 2'b00});
                                asm_cnt_d = asm_cnt_q + 32'd1;
                            end
                        end
                    end
`ifdef UART_PROGRAMMER_CHECKSUM_EN
                    else if (!csum_seen_q) begin
                        // Checksum arrived before the last grant; keep it.
                        csum_seen_d = 1'b1;
                        csum_byte_d = rx_shift_q;
                    end
`endif
                end
            end
`ifdef UART_PROGRAMMER_CHECKSUM_EN
            S_CSUM: begin
                if (csum_seen_q) begin
                    state_d = (csum_byte_q == csum_q) ? S_DONE : S_ERROR;
                end else if (byte_valid_q) begin
                    state_d = (rx_shift_q == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_ERROR: req_d = 1'b0;
            default: ;
        endcase
        if (frame_err_q && in_session) begin
            state_d = S_ERROR;
            req_d   = 1'b0;
        end
    end

    // Session state register. The enable strap acts as a second
    // synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!reset_ni || !programmer_enable_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            asm_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            req_q      <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
`ifdef UART_PROGRAMMER_CHECKSUM_EN
            csum_q      <= '0;
            csum_byte_q <= '0;
            csum_seen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            asm_cnt_q  <= asm_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef UART_PROGRAMMER_CHECKSUM_EN
            csum_q      <= csum_d;
            csum_byte_q <= csum_byte_d;
            csum_seen_q <= csum_seen_d;
`endif
        end
    end

    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = in_session;
    assign done_o      = (state_q == S_DONE);
    assign error_o     = (state_q == S_ERROR);

endmodule

// File: tb/tb_uart_programmer.sv
// Directed testbench for uart_programmer: 1 MHz clock, 100 kbaud (10 clks/bit),
// BASE_ADDR 0x100. Honours UART_PROGRAMMER_CHECKSUM_EN if defined.
`timescale 1ns/1ps
module tb_uart_programmer;

    localparam int CPB = 10;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic        rx       = 1'b1;
    logic        gnt      = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, error;

    uart_programmer #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD_RATE   (100_000),
        .ADDR_WIDTH  (32),
        .BASE_ADDR   (32'h0000_0100)
    ) dut (
        .clk_i               (clk),
        .reset_ni            (reset_n),
        .programmer_enable_i (enable),
        .programmer_rx       (rx),
        .mem_req_o           (req),
        .mem_addr_o          (addr),
        .mem_wdata_o         (wdata),
        .mem_gnt_i           (gnt),
        .busy_o              (busy),
        .done_o              (done),
        .error_o             (error)
    );

    always #500 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Write monitor: only ever appends, tests remember the start index.
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_n       = 0;
    int          req_cycles = 0;

    always @(negedge clk) begin
        if (req) req_cycles = req_cycles + 1;
        if (req && gnt && wr_n < 64) begin
            wr_addr[wr_n] = addr;
            wr_data[wr_n] = wdata;
            wr_n = wr_n + 1;
            $display("write addr=0x%08h data=0x%08h", addr, wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Packet A: LEN=2, words 0x12345678 and 0xDEADBEEF.
    // XOR of 02 00 00 00 78 56 34 12 EF BE AD DE = 0x28.
    task automatic send_pkt_a(input logic [7:0] csum);
        logic [7:0] pkt [12];
        pkt = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 12; i++) send_byte(pkt[i], 1'b1);
`ifdef UART_PROGRAMMER_CHECKSUM_EN
        send_byte(csum, 1'b1);
`else
        if (csum == 8'hFF) rx = 1'b1;  // checksum byte is not sent without the option
`endif
    endtask

    task automatic wait_end(input string tag, input int budget);
        for (int i = 0; i < budget && !(done || error); i++) @(negedge clk);
        check_eq(tag, {31'd0, done | error}, 32'd1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && !req; i++) @(negedge clk);
        check_eq(tag, {31'd0, req}, 32'd1);
    endtask

    task automatic new_session();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_pkt_a(input string tag, input int base);
        check_eq({tag, "_nwr"},   wr_n - base, 32'd2);
        check_eq({tag, "_addr0"}, wr_addr[base],     32'h0000_0100);
        check_eq({tag, "_data0"}, wr_data[base],     32'h1234_5678);
        check_eq({tag, "_addr1"}, wr_addr[base + 1], 32'h0000_0104);
        check_eq({tag, "_data1"}, wr_data[base + 1], 32'hDEAD_BEEF);
        check_eq({tag, "_done"},  {31'd0, done},  32'd1);
        check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, busy},  32'd0);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int r0;
        repeat (3) @(negedge clk);
        check_eq("rst_req",   {31'd0, req},   32'd0);
        check_eq("rst_addr",  addr,           32'h0000_0100);
        check_eq("rst_wdata", wdata,          32'd0);
        check_eq("rst_busy",  {31'd0, busy},  32'd0);
        check_eq("rst_done",  {31'd0, done},  32'd0);
        check_eq("rst_error", {31'd0, error}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Nominal image
        $display("packet A nominal");
        base = wr_n;
        new_session();
        check_eq("a_busy_start", {31'd0, busy}, 32'd1);
        send_pkt_a(8'h28);
        wait_end("a_end", 200);
        check_pkt_a("a", base);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("off_done", {31'd0, done}, 32'd0);

`ifdef UART_PROGRAMMER_CHECKSUM_EN
        $display("packet A bad checksum");
        new_session();
        send_pkt_a(8'h00);
        wait_end("badcs_end", 200);
        check_eq("badcs_error", {31'd0, error}, 32'd1);
        check_eq("badcs_done",  {31'd0, done},  32'd0);
`endif

        // Framing error on the 3rd byte
        $display("framing error");
        new_session();
        r0 = req_cycles;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        wait_end("fr_end", 50);
        check_eq("fr_error", {31'd0, error}, 32'd1);
        check_eq("fr_noreq", req_cycles - r0, 32'd0);
        check_eq("fr_done",  {31'd0, done},  32'd0);

        // Glitch then LEN=0
        $display("glitch then LEN=0");
        new_session();
        base = wr_n;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("gl_busy",  {31'd0, busy},  32'd1);
        check_eq("gl_error", {31'd0, error}, 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
`ifdef UART_PROGRAMMER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        wait_end("gl_end", 50);
        check_eq("gl_done",   {31'd0, done},  32'd1);
        check_eq("gl_error2", {31'd0, error}, 32'd0);
        check_eq("gl_nwr",    wr_n - base,    32'd0);

        // Grant held low: hold then overrun
        $display("grant low overrun");
        gnt = 1'b0;
        new_session();
        base = wr_n;
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        wait_req("ov_req", 20);
        check_eq("ov_addr", addr,  32'h0000_0100);
        check_eq("ov_data", wdata, 32'h1234_5678);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1);
        check_eq("ov_hold_req",  {31'd0, req}, 32'd1);
        check_eq("ov_hold_addr", addr,  32'h0000_0100);
        check_eq("ov_hold_data", wdata, 32'h1234_5678);
        send_byte(8'hDE, 1'b1);
        wait_end("ov_end", 50);
        check_eq("ov_error", {31'd0, error}, 32'd1);
        check_eq("ov_req_off", {31'd0, req}, 32'd0);
        check_eq("ov_nwr", wr_n - base, 32'd0);

        // Enable drop with a request in flight, then a fresh image
        $display("enable drop mid-DATA");
        new_session();
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        wait_req("ed_req", 20);
        enable = 1'b0;
        @(negedge clk);
        check_eq("ed_busy",  {31'd0, busy}, 32'd0);
        check_eq("ed_req0",  {31'd0, req},  32'd0);
        check_eq("ed_addr",  addr,          32'h0000_0100);
        check_eq("ed_wdata", wdata,         32'd0);
        gnt = 1'b1;
        base = wr_n;
        new_session();
        send_pkt_a(8'h28);
        wait_end("ed_end", 200);
        check_pkt_a("ed", base);

        // Reset pulse in the middle of a data byte, then a fresh image
        $display("reset pulse mid-DATA");
        new_session();
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        rx = 1'b0;
        repeat (25) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rs_busy",  {31'd0, busy},  32'd0);
        check_eq("rs_req",   {31'd0, req},   32'd0);
        check_eq("rs_error", {31'd0, error}, 32'd0);
        rx = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        base = wr_n;
        send_pkt_a(8'h28);
        wait_end("rs_end", 200);
        check_pkt_a("rs", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
